// File: rtl/ps2_key_writer.sv
// PS/2 keyboard to LCD character-memory writer.
// Receives PS/2 frames, decodes set-2 scan codes to ASCII and writes
// characters at a cursor into the line-1 or line-2 character memory.
// After reset both memories are filled with spaces before keys are accepted.
module ps2_key_writer #(
    parameter int LINE_LEN    = 16,
    parameter int TIMEOUT_CYC = 50000,
    localparam int CW         = $clog2(2 * LINE_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic          wr_en_1,
    output logic          wr_en_2,
    output logic [5:0]    wr_addr,
    output logic [8:0]    wr_data,
    output logic [CW-1:0] cursor,
    output logic          frame_err
);

    localparam int LW = CW - 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_DECODE,
        S_WRITE
    } state_t;

    // Set-2 make code -> {valid, is_letter, uppercase ascii}.
    function automatic logic [9:0] scan_lut(input logic [7:0] code);
        logic [9:0] r;
        r = '0;
        case (code)
            8'h1C: r = {2'b11, 8'h41}; 8'h32: r = {2'b11, 8'h42};
            8'h21: r = {2'b11, 8'h43}; 8'h23: r = {2'b11, 8'h44};
            8'h24: r = {2'b11, 8'h45}; 8'h2B: r = {2'b11, 8'h46};
            8'h34: r = {2'b11, 8'h47}; 8'h33: r = {2'b11, 8'h48};
            8'h43: r = {2'b11, 8'h49}; 8'h3B: r = {2'b11, 8'h4A};
            8'h42: r = {2'b11, 8'h4B}; 8'h4B: r = {2'b11, 8'h4C};
            8'h3A: r = {2'b11, 8'h4D}; 8'h31: r = {2'b11, 8'h4E};
            8'h44: r = {2'b11, 8'h4F}; 8'h4D: r = {2'b11, 8'h50};
            8'h15: r = {2'b11, 8'h51}; 8'h2D: r = {2'b11, 8'h52};
            8'h1B: r = {2'b11, 8'h53}; 8'h2C: r = {2'b11, 8'h54};
            8'h3C: r = {2'b11, 8'h55}; 8'h2A: r = {2'b11, 8'h56};
            8'h1D: r = {2'b11, 8'h57}; 8'h22: r = {2'b11, 8'h58};
            8'h35: r = {2'b11, 8'h59}; 8'h1A: r = {2'b11, 8'h5A};
            8'h45: r = {2'b10, 8'h30}; 8'h16: r = {2'b10, 8'h31};
            8'h1E: r = {2'b10, 8'h32}; 8'h26: r = {2'b10, 8'h33};
            8'h25: r = {2'b10, 8'h34}; 8'h2E: r = {2'b10, 8'h35};
            8'h36: r = {2'b10, 8'h36}; 8'h3D: r = {2'b10, 8'h37};
            8'h3E: r = {2'b10, 8'h38}; 8'h46: r = {2'b10, 8'h39};
            8'h29: r = {2'b10, 8'h20};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Synchronisers: [0] first stage, clock chain keeps one extra stage for edge detect.
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [1:0] dat_sync_q, dat_sync_d;

    // Receiver state.
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          frame_err_q, frame_err_d;

    // Decoder / writer state.
    state_t        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic [7:0]    code_q, code_d;
    logic          shift_q, shift_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          bs_q, bs_d;
    logic          wr_en_1_q, wr_en_1_d;
    logic          wr_en_2_q, wr_en_2_d;
    logic [5:0]    wr_addr_q, wr_addr_d;
    logic [8:0]    wr_data_q, wr_data_d;

    logic          fall;
    logic          bit_in;
    logic [10:0]   frame;
    logic          frame_ok;
    logic          frame_bad;
    logic [9:0]    lut;
    logic          is_shift;
    logic          do_write;
    logic [7:0]    wr_char;
    logic [CW-1:0] wr_pos;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_in = dat_sync_q[1];
    // frame[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
    assign frame  = {bit_in, shreg_q};

    // Receiver: synchronise, shift in bits on falling edges, validate frame, time out partial frames.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        to_cnt_d    = to_cnt_q;
        byte_d      = byte_q;
        byte_vld_d  = byte_vld_q;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;

        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!frame[0] && (^frame[9:1]) && frame[10]) frame_ok  = 1'b1;
                else                                          frame_bad = 1'b1;
            end else begin
                shreg_d   = {bit_in, shreg_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                frame_bad = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        // Holding register: consumed in IDLE, a freshly received byte wins.
        if (state_q == S_IDLE && byte_vld_q) byte_vld_d = 1'b0;
        if (frame_ok) begin
            byte_vld_d = 1'b1;
            byte_d     = frame[8:1];
        end
        frame_err_d = frame_bad;
    end

    // FSM next state: memory clear, byte consume, decode, write with cursor advance.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cursor_d  = cursor_q;
        code_d    = code_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        bs_d      = bs_q;
        wr_en_1_d = 1'b0;
        wr_en_2_d = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        lut       = scan_lut(code_q);
        is_shift  = (code_q == 8'h12) || (code_q == 8'h59);
        do_write  = 1'b0;
        wr_char   = 8'h20;
        wr_pos    = cursor_q;

        case (state_q)
            S_CLEAR: begin
                cursor_d  = '0;
                wr_en_1_d = ~clr_cnt_q[CW-1];
                wr_en_2_d = clr_cnt_q[CW-1];
                wr_addr_d = 6'(clr_cnt_q[LW-1:0]);
                wr_data_d = 9'h120;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (byte_vld_q) begin
                    code_d  = byte_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (code_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (code_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                    if (is_shift) shift_d = 1'b0;
                end else if (ext_q) begin
                    ext_d = 1'b0;
                end else if (is_shift) begin
                    shift_d = 1'b1;
                end else if (code_q == 8'h5A) begin
                    cursor_d = cursor_q[CW-1] ? '0 : {1'b1, {LW{1'b0}}};
                end else if (code_q == 8'h66) begin
                    if (cursor_q != '0) begin
                        cursor_d = cursor_q - 1'b1;
                        wr_pos   = cursor_q - 1'b1;
                        wr_char  = 8'h20;
                        bs_d     = 1'b1;
                        do_write = 1'b1;
                    end
                end else if (lut[9]) begin
                    wr_char  = (lut[8] && !shift_q) ? (lut[7:0] | 8'h20) : lut[7:0];
                    bs_d     = 1'b0;
                    do_write = 1'b1;
                end

                if (do_write) begin
                    state_d   = S_WRITE;
                    wr_en_1_d = ~wr_pos[CW-1];
                    wr_en_2_d = wr_pos[CW-1];
                    wr_addr_d = 6'(wr_pos[LW-1:0]);
                    wr_data_d = {1'b1, wr_char};
                end
            end
            S_WRITE: begin
                // Backspace already moved the cursor; a full-range counter wraps naturally.
                if (!bs_q) cursor_d = cursor_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            to_cnt_q    <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= S_CLEAR;
            clr_cnt_q   <= '0;
            cursor_q    <= '0;
            code_q      <= '0;
            shift_q     <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            bs_q        <= 1'b0;
            wr_en_1_q   <= 1'b0;
            wr_en_2_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            to_cnt_q    <= to_cnt_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            cursor_q    <= cursor_d;
            code_q      <= code_d;
            shift_q     <= shift_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            bs_q        <= bs_d;
            wr_en_1_q   <= wr_en_1_d;
            wr_en_2_q   <= wr_en_2_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en_1   = wr_en_1_q;
    assign wr_en_2   = wr_en_2_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cursor    = cursor_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_writer.sv
// Directed bench for ps2_key_writer: bit-bangs PS/2 frames and checks the
// memory write stream, cursor and frame-error pulses against hand-computed values.
module tb_ps2_key_writer;

    localparam int L  = 16;
    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       wr_en_1, wr_en_2, frame_err;
    logic [5:0] wr_addr;
    logic [8:0] wr_data;
    logic [4:0] cursor;

    ps2_key_writer #(.LINE_LEN(L), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .wr_en_1   (wr_en_1),
        .wr_en_2   (wr_en_2),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor    (cursor),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       line2;
        logic [5:0] addr;
        logic [8:0] data;
        int         at;
    } wr_t;

    wr_t wq[$];
    int  err_seen  = 0;
    int  overlap   = 0;
    int  last_fall = 0;
    int  n_checks  = 0;
    int  n_errors  = 0;

    // Write/error monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en_1 || wr_en_2) wq.push_back('{wr_en_2, wr_addr, wr_data, cyc});
        if (wr_en_1 && wr_en_2) overlap++;
        if (frame_err) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the first n bits of an 11-bit frame, LSB (start) first.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ps2_data = bits[i];
            repeat (8) @(posedge clk);
            #1 ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (10) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic send_key(input logic [7:0] code, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        send_bits(f, 11);
        repeat (10) @(posedge clk);
    endtask

    task automatic expect_wr(input string tag, input bit line2, input int addr, input int data);
        wr_t w;
        for (int i = 0; i < 100 && wq.size() == 0; i++) @(negedge clk);
        if (wq.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            w = wq.pop_front();
            check({tag, "_line"}, 32'(w.line2), 32'(line2));
            check({tag, "_addr"}, 32'(w.addr), 32'(addr));
            check({tag, "_data"}, 32'(w.data), 32'(data));
        end
    endtask

    task automatic expect_clear(input string tag);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 2 * L; i++) expect_wr(tag, i >= L, i % L, 'h120);
        check({tag, "_extra"}, 32'(wq.size()), 32'd0);
    endtask

    initial begin
        int e0;
        wr_t w;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en_1", 32'(wr_en_1), 32'd0);
        check("rst_wr_en_2", 32'(wr_en_2), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;

        // Clear sequence: 16 line-1 then 16 line-2 spaces
        expect_clear("clr");
        check("cursor_after_clr", 32'(cursor), 32'd0);

        // 'a' with latency: wr_en five cycles after the stop edge is driven
        send_key(8'h1C, 1'b0);
        if (wq.size() > 0) begin
            w = wq[0];
            check("latency_a", 32'(w.at - last_fall), 32'd5);
        end
        expect_wr("key_a", 1'b0, 0, 'h161);
        check("cursor_a", 32'(cursor), 32'd1);

        // Shift make, 'A', shift break, 'a'
        send_key(8'h12, 1'b0);
        send_key(8'h1C, 1'b0);
        send_key(8'hF0, 1'b0);
        send_key(8'h12, 1'b0);
        send_key(8'h1C, 1'b0);
        expect_wr("shift_A", 1'b0, 1, 'h141);
        expect_wr("unshift_a", 1'b0, 2, 'h161);
        check("shift_no_extra", 32'(wq.size()), 32'd0);
        check("cursor_shift", 32'(cursor), 32'd3);

        // Bad parity
        e0 = err_seen;
        send_key(8'h1C, 1'b1);
        check("parity_err", 32'(err_seen - e0), 32'd1);
        check("parity_no_wr", 32'(wq.size()), 32'd0);
        check("parity_cursor", 32'(cursor), 32'd3);

        // Digits to reach cursor 5, Enter to line 2
        send_key(8'h16, 1'b0);
        send_key(8'h1E, 1'b0);
        expect_wr("dig1", 1'b0, 3, 'h131);
        expect_wr("dig2", 1'b0, 4, 'h132);
        check("cursor_5", 32'(cursor), 32'd5);
        send_key(8'h5A, 1'b0);
        check("enter_to_16", 32'(cursor), 32'd16);
        check("enter_no_wr", 32'(wq.size()), 32'd0);
        send_key(8'h16, 1'b0);
        expect_wr("line2_1", 1'b1, 0, 'h131);
        check("cursor_17", 32'(cursor), 32'd17);

        // Fill line 2 up to position 30, then wrap
        for (int i = 17; i < 31; i++) begin
            send_key(8'h45, 1'b0);
            expect_wr("fill0", 1'b1, i - 16, 'h130);
        end
        check("cursor_31", 32'(cursor), 32'd31);
        send_key(8'h1A, 1'b0);
        expect_wr("wrap_z", 1'b1, 15, 'h17A);
        check("cursor_wrap", 32'(cursor), 32'd0);

        // Backspace at 0 does nothing; after a char it blanks it
        send_key(8'h66, 1'b0);
        check("bs0_no_wr", 32'(wq.size()), 32'd0);
        check("bs0_cursor", 32'(cursor), 32'd0);
        send_key(8'h32, 1'b0);
        expect_wr("key_b", 1'b0, 0, 'h162);
        send_key(8'h66, 1'b0);
        expect_wr("bs_blank", 1'b0, 0, 'h120);
        check("bs_cursor", 32'(cursor), 32'd0);

        // Extended codes and unknown codes produce nothing
        send_key(8'hE0, 1'b0);
        send_key(8'h1C, 1'b0);
        send_key(8'hE0, 1'b0);
        send_key(8'hF0, 1'b0);
        send_key(8'h1C, 1'b0);
        send_key(8'h05, 1'b0);
        check("ext_no_wr", 32'(wq.size()), 32'd0);
        check("ext_cursor", 32'(cursor), 32'd0);

        // Enter from line 2 returns to 0
        send_key(8'h5A, 1'b0);
        check("enter_0_16", 32'(cursor), 32'd16);
        send_key(8'h5A, 1'b0);
        check("enter_16_0", 32'(cursor), 32'd0);

        // Timeout on partial frame, then a full space frame
        e0 = err_seen;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
        repeat (TO + 50) @(posedge clk);
        check("timeout_err", 32'(err_seen - e0), 32'd1);
        send_key(8'h29, 1'b0);
        expect_wr("after_to_space", 1'b0, 0, 'h120);
        check("cursor_after_to", 32'(cursor), 32'd1);

        // Reset mid-frame: clear restarts, partial bits discarded
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_cursor", 32'(cursor), 32'd0);
        check("midrst_wr_en", 32'({wr_en_1, wr_en_2}), 32'd0);
        wq.delete();
        @(posedge clk); #1 rst = 1'b0;
        expect_clear("clr2");
        send_key(8'h1C, 1'b0);
        expect_wr("post_rst_a", 1'b0, 0, 'h161);

        check("no_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "simulation time bound expired");
    end

endmodule
